// File: rtl/frame_src_mux.sv
// Selects one of NUM_SRC synchronous video sources, converts its pixel format to {R,G,B,ALPHA}
// and only changes source or format on frame boundaries. Also checks the pixel count of each frame.
module frame_src_mux #(
    parameter int          NUM_SRC = 4,
    parameter int          SRC_H   = 800,
    parameter int          SRC_V   = 480,
    parameter logic [7:0]  ALPHA   = 8'hFF,
    localparam int         SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NUM_SRC-1:0]    src_vs,
    input  logic [NUM_SRC-1:0]    src_de,
    input  logic [24*NUM_SRC-1:0] src_data,
    input  logic [SEL_W-1:0]      sel_req,
    input  logic [1:0]            fmt_req,
    output logic                  out_vs,
    output logic                  out_de,
    output logic [31:0]           out_data,
    output logic [SEL_W-1:0]      cur_sel,
    output logic [1:0]            cur_fmt,
    output logic                  switch_pending,
    output logic [15:0]           frame_cnt,
    output logic                  err_pulse,
    output logic [7:0]            err_cnt
);

    // state    | meaning
    // WAIT_SOF | output blanked, waiting for a start-of-frame on cur_sel
    // ACTIVE   | frames from cur_sel are forwarded with one cycle of latency
    typedef enum logic {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [23:0] FRAME_PIX = 24'(SRC_H * SRC_V);

    state_t              state, state_nxt;
    logic [NUM_SRC-1:0]  src_vs_d;
    logic [NUM_SRC-1:0]  sof;
    logic                sof_sel;
    logic                de_sel;
    logic [23:0]         sel_d;
    logic                req_valid;
    logic                pend;
    logic                new_src;
    logic                new_fmt_only;
    logic [SEL_W-1:0]    sel_nxt;
    logic [1:0]          fmt_nxt;
    logic                pass;
    logic                take;
    logic                check;
    logic [23:0]         pix_cnt;
    logic [23:0]         rgb;

    assign sof       = src_vs & ~src_vs_d;
    assign sof_sel   = sof[cur_sel];
    assign de_sel    = src_de[cur_sel];
    assign sel_d     = src_data[24*cur_sel +: 24];

    // Out-of-range source requests are ignored as if nothing were requested.
    assign req_valid    = 32'(sel_req) < NUM_SRC;
    assign pend         = req_valid && ({sel_req, fmt_req} != {cur_sel, cur_fmt});
    assign new_src      = pend && (sel_req != cur_sel);
    assign new_fmt_only = pend && (sel_req == cur_sel);

    always_comb begin
        state_nxt = state;
        sel_nxt   = cur_sel;
        fmt_nxt   = cur_fmt;
        pass      = 1'b0;
        take      = 1'b0;
        check     = 1'b0;
        case (state)
            WAIT_SOF: begin
                if (sof_sel) begin
                    if (new_src) begin
                        sel_nxt = sel_req;
                        fmt_nxt = fmt_req;
                    end else begin
                        if (new_fmt_only) fmt_nxt = fmt_req;
                        state_nxt = ACTIVE;
                        pass      = 1'b1;
                        take      = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                pass = 1'b1;
                if (sof_sel) begin
                    if (new_src) begin
                        // The frame boundary belongs to the old source: drop it and
                        // wait for a later SOF from the new one.
                        sel_nxt   = sel_req;
                        fmt_nxt   = fmt_req;
                        state_nxt = WAIT_SOF;
                        pass      = 1'b0;
                    end else begin
                        if (new_fmt_only) fmt_nxt = fmt_req;
                        take  = 1'b1;
                        check = (pix_cnt != FRAME_PIX);
                    end
                end
            end
            default: state_nxt = WAIT_SOF;
        endcase
    end

    // Conversion uses the format that applies from this cycle on, so a format
    // change takes effect from the SOF cycle of the new frame.
    always_comb begin
        case (fmt_nxt)
            2'd1:    rgb = {3{sel_d[7:0]}};
            2'd2:    rgb = {sel_d[15:11], sel_d[15:13], sel_d[10:5], sel_d[10:9],
                            sel_d[4:0], sel_d[4:2]};
            default: rgb = sel_d;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= WAIT_SOF;
            src_vs_d       <= '0;
            cur_sel        <= '0;
            cur_fmt        <= 2'd0;
            out_vs         <= 1'b0;
            out_de         <= 1'b0;
            out_data       <= 32'd0;
            switch_pending <= 1'b0;
            frame_cnt      <= 16'd0;
            err_pulse      <= 1'b0;
            err_cnt        <= 8'd0;
            pix_cnt        <= 24'd0;
        end else begin
            state          <= state_nxt;
            src_vs_d       <= src_vs;
            cur_sel        <= sel_nxt;
            cur_fmt        <= fmt_nxt;
            out_vs         <= pass & src_vs[cur_sel];
            out_de         <= pass & de_sel;
            out_data       <= (pass && de_sel) ? {rgb, ALPHA} : 32'd0;
            switch_pending <= pend;
            err_pulse      <= check;
            if (take) frame_cnt <= frame_cnt + 16'd1;
            if (check && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
            // The counter tracks pixels that will appear on out_de one cycle later.
            if (take)
                pix_cnt <= {23'd0, de_sel};
            else if (pass && de_sel && (pix_cnt != 24'hFF_FFFF))
                pix_cnt <= pix_cnt + 24'd1;
        end
    end

endmodule

// File: tb/tb_frame_src_mux.sv
// Directed bench for frame_src_mux with 3 sources and 4x2 frames; expected values are hand-computed.
module tb_frame_src_mux;

    localparam int NS = 3;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [NS-1:0]   src_vs = '0;
    logic [NS-1:0]   src_de = '0;
    logic [24*NS-1:0] src_data = '0;
    logic [SW-1:0]   sel_req = '0;
    logic [1:0]      fmt_req = 2'd0;
    logic            out_vs;
    logic            out_de;
    logic [31:0]     out_data;
    logic [SW-1:0]   cur_sel;
    logic [1:0]      cur_fmt;
    logic            switch_pending;
    logic [15:0]     frame_cnt;
    logic            err_pulse;
    logic [7:0]      err_cnt;

    int   n_checks = 0;
    int   n_errors = 0;
    logic sof_err;
    logic sof_err_next;

    frame_src_mux #(
        .NUM_SRC (NS),
        .SRC_H   (4),
        .SRC_V   (2),
        .ALPHA   (8'hFF)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .src_vs         (src_vs),
        .src_de         (src_de),
        .src_data       (src_data),
        .sel_req        (sel_req),
        .fmt_req        (fmt_req),
        .out_vs         (out_vs),
        .out_de         (out_de),
        .out_data       (out_data),
        .cur_sel        (cur_sel),
        .cur_fmt        (cur_fmt),
        .switch_pending (switch_pending),
        .frame_cnt      (frame_cnt),
        .err_pulse      (err_pulse),
        .err_cnt        (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One frame: 1-cycle vsync, 1 gap cycle, npix pixels of constant data, 1 idle cycle.
    task automatic send_frame(input int src, input int npix, input logic [23:0] d,
                              input logic [31:0] exp, input logic pass);
        int seen;
        seen = 0;
        src_vs[src] = 1'b1;
        tick();
        chk("sof_out_vs", {31'd0, out_vs}, {31'd0, pass});
        sof_err = err_pulse;
        src_vs[src] = 1'b0;
        tick();
        sof_err_next = err_pulse;
        for (int i = 0; i < npix; i++) begin
            src_de[src] = 1'b1;
            src_data[src*24 +: 24] = d;
            tick();
            if (out_de) begin
                seen++;
                chk("pixel_data", out_data, exp);
            end
        end
        src_de[src] = 1'b0;
        src_data[src*24 +: 24] = 24'd0;
        tick();
        chk("blank_data", out_data, 32'd0);
        chk("de_count", 32'(seen), pass ? 32'(npix) : 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_flags", {28'd0, out_vs, out_de, switch_pending, err_pulse}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_sel_fmt", {28'd0, cur_sel, cur_fmt}, 32'd0);
        rstn = 1'b1;
        tick();

        // Source 0, RGB888, three frames
        send_frame(0, 8, 24'h123456, 32'h123456FF, 1'b1);
        chk("frame_cnt_1", {16'd0, frame_cnt}, 32'd1);
        send_frame(0, 8, 24'hABCDEF, 32'hABCDEFFF, 1'b1);
        chk("frame_cnt_2", {16'd0, frame_cnt}, 32'd2);
        send_frame(0, 8, 24'h0F1E2D, 32'h0F1E2DFF, 1'b1);
        chk("frame_cnt_3", {16'd0, frame_cnt}, 32'd3);
        chk("err_cnt_good", {24'd0, err_cnt}, 32'd0);

        // Same source, switch to RAW8 at the next SOF
        fmt_req = 2'd1;
        tick();
        chk("pending_fmt", {31'd0, switch_pending}, 32'd1);
        send_frame(0, 8, 24'h00005A, 32'h5A5A5AFF, 1'b1);
        chk("fmt_raw8", {30'd0, cur_fmt}, 32'd1);
        chk("frame_cnt_4", {16'd0, frame_cnt}, 32'd4);
        chk("pending_fmt_clr", {31'd0, switch_pending}, 32'd0);

        // Source 0 -> 2: held until sof[0], then blank until sof[2]
        sel_req = 2'd2;
        fmt_req = 2'd0;
        tick();
        tick();
        chk("pending_src", {31'd0, switch_pending}, 32'd1);
        chk("sel_held", {30'd0, cur_sel}, 32'd0);
        send_frame(0, 8, 24'h999999, 32'h0, 1'b0);
        chk("sel_switched", {30'd0, cur_sel}, 32'd2);
        chk("frame_cnt_switch", {16'd0, frame_cnt}, 32'd4);
        chk("pending_src_clr", {31'd0, switch_pending}, 32'd0);
        send_frame(2, 8, 24'h102030, 32'h102030FF, 1'b1);
        chk("frame_cnt_5", {16'd0, frame_cnt}, 32'd5);
        send_frame(2, 8, 24'h405060, 32'h405060FF, 1'b1);
        chk("frame_cnt_6", {16'd0, frame_cnt}, 32'd6);
        chk("err_cnt_switch", {24'd0, err_cnt}, 32'd0);

        // Source 2 -> 1 in RGB565
        sel_req = 2'd1;
        fmt_req = 2'd2;
        send_frame(2, 8, 24'h777777, 32'h0, 1'b0);
        chk("sel_1_fmt_2", {28'd0, cur_sel, cur_fmt}, 32'h6);
        send_frame(1, 8, 24'h00F81F, 32'hFF00FFFF, 1'b1);
        chk("frame_cnt_7", {16'd0, frame_cnt}, 32'd7);
        send_frame(1, 8, 24'h008410, 32'h848284FF, 1'b1);
        chk("frame_cnt_8", {16'd0, frame_cnt}, 32'd8);

        // New source's SOF coincides with the switch SOF: not taken
        sel_req = 2'd2;
        fmt_req = 2'd0;
        tick();
        chk("pending_coinc", {31'd0, switch_pending}, 32'd1);
        src_vs[1] = 1'b1;
        src_vs[2] = 1'b1;
        tick();
        chk("coinc_out_vs", {31'd0, out_vs}, 32'd0);
        chk("coinc_sel", {30'd0, cur_sel}, 32'd2);
        src_vs = '0;
        src_de[2] = 1'b1;
        src_data[48 +: 24] = 24'h555555;
        tick();
        chk("coinc_no_entry", {31'd0, out_de}, 32'd0);
        src_de[2] = 1'b0;
        src_data[48 +: 24] = 24'd0;
        tick();
        send_frame(2, 8, 24'h0A0B0C, 32'h0A0B0CFF, 1'b1);
        chk("frame_cnt_9", {16'd0, frame_cnt}, 32'd9);

        // Out-of-range select is ignored
        sel_req = 2'd3;
        tick();
        tick();
        chk("invalid_no_pending", {31'd0, switch_pending}, 32'd0);
        send_frame(2, 8, 24'hC0FFEE, 32'hC0FFEEFF, 1'b1);
        chk("invalid_sel_kept", {30'd0, cur_sel}, 32'd2);
        chk("frame_cnt_10", {16'd0, frame_cnt}, 32'd10);

        // Back to source 0, then a 7-pixel frame
        sel_req = 2'd0;
        send_frame(2, 8, 24'h666666, 32'h0, 1'b0);
        send_frame(0, 8, 24'h111111, 32'h111111FF, 1'b1);
        chk("entry_no_err", {31'd0, sof_err}, 32'd0);
        chk("frame_cnt_11", {16'd0, frame_cnt}, 32'd11);
        send_frame(0, 7, 24'h222222, 32'h222222FF, 1'b1);
        chk("good_frame_no_err", {31'd0, sof_err}, 32'd0);
        send_frame(0, 8, 24'h333333, 32'h333333FF, 1'b1);
        chk("short_err_pulse", {31'd0, sof_err}, 32'd1);
        chk("short_err_one_cycle", {31'd0, sof_err_next}, 32'd0);
        chk("short_err_cnt", {24'd0, err_cnt}, 32'd1);
        chk("frame_cnt_13", {16'd0, frame_cnt}, 32'd13);

        // 300 one-pixel frames: err_cnt saturates
        for (int k = 0; k < 300; k++)
            send_frame(0, 1, 24'h444444, 32'h444444FF, 1'b1);
        chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
        send_frame(0, 8, 24'h010101, 32'h010101FF, 1'b1);
        chk("err_cnt_sat_hold", {24'd0, err_cnt}, 32'd255);
        chk("frame_cnt_314", {16'd0, frame_cnt}, 32'd314);

        // Reset in the middle of a frame
        src_vs[0] = 1'b1;
        tick();
        src_vs[0] = 1'b0;
        src_de[0] = 1'b1;
        src_data[0 +: 24] = 24'h777777;
        tick();
        tick();
        chk("pre_reset_de", {31'd0, out_de}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_flags", {28'd0, out_vs, out_de, switch_pending, err_pulse}, 32'd0);
        chk("async_rst_data", out_data, 32'd0);
        chk("async_rst_cnts", {8'd0, frame_cnt, err_cnt}, 32'd0);
        src_de[0] = 1'b0;
        src_data[0 +: 24] = 24'd0;
        @(negedge clk);
        rstn = 1'b1;
        src_de[0] = 1'b1;
        src_data[0 +: 24] = 24'h888888;
        tick();
        chk("post_rst_blank", {31'd0, out_de}, 32'd0);
        src_de[0] = 1'b0;
        src_data[0 +: 24] = 24'd0;
        tick();
        send_frame(0, 8, 24'h010203, 32'h010203FF, 1'b1);
        chk("post_rst_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        chk("post_rst_err_cnt", {24'd0, err_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_src_mux.md
FRAME_SRC_MUX -- requirements
Module: frame_src_mux

Interface
REQ-001 Parameter NUM_SRC, default 4, number of video sources (2..8).
REQ-002 Parameter SRC_H, default 800, expected active pixels per line.
REQ-003 Parameter SRC_V, default 480, expected active lines per frame.
REQ-004 Parameter ALPHA, default 8'hFF, constant low byte of out_data.
REQ-005 Clock and reset ports: clk, one clock; rstn, reset asynchronous and active-low.
REQ-006 Ports (name, direction, width, meaning):
- clk, in, 1: the single clock; all sources are synchronous to it.
- rstn, in, 1: async active-low reset.
- src_vs, in, NUM_SRC: per-source vsync, active high; a rising edge is start-of-frame (SOF).
- src_de, in, NUM_SRC: per-source pixel valid.
- src_data, in, 24*NUM_SRC: per-source pixel; source i occupies [24i+23:24i].
- sel_req, in, clog2(NUM_SRC): requested source.
- fmt_req, in, 2: requested format. 0 = RGB888 in [23:0]; 1 = RAW8 in [7:0]; 2 = RGB565 in [15:0]; 3 = reserved.
- out_vs, out, 1: selected vsync; drives the frame-buffer write load.
- out_de, out, 1: write enable.
- out_data, out, 32: {R,G,B,ALPHA}.
- cur_sel, out, clog2(NUM_SRC): active source.
- cur_fmt, out, 2: active format.
- switch_pending, out, 1: a request is waiting for a frame boundary.
- frame_cnt, out, 16: frames passed; wraps.
- err_pulse, out, 1: one-cycle pixel-count mismatch strobe.
- err_cnt, out, 8: mismatch count; saturates at 255.

Function
REQ-007 Edge detection: a registered copy of every src_vs bit is kept at all times; sof[i] = src_vs[i] & ~src_vs_d[i].
REQ-008 State machine has two states, WAIT_SOF and ACTIVE.
REQ-009 WAIT_SOF: out_vs=0 and out_de=0; on sof[cur_sel], go to ACTIVE and increment frame_cnt.
REQ-010 ACTIVE: out_vs, out_de and out_data are registered from source cur_sel, with 1-cycle latency; the SOF cycle itself is passed through.
REQ-011 A request is pending when {sel_req,fmt_req} != {cur_sel,cur_fmt} and sel_req < NUM_SRC; a sel_req >= NUM_SRC is ignored entirely.
REQ-012 Each cycle the pending request is re-evaluated from the live inputs; switch_pending is registered, so it lags the inputs by 1 cycle.
REQ-013 Pending request with a different source, on sof[cur_sel] in ACTIVE:
- load cur_sel and cur_fmt;
- go to WAIT_SOF;
- that SOF is not passed (out_vs=0 next cycle);
- frame_cnt does not increment.
REQ-014 Pending request with the same source and a different format, on sof[cur_sel] in ACTIVE: load cur_fmt, stay ACTIVE, and pass the frame in the new format.
REQ-015 A sof of the new source that coincides with the switch cycle is not taken; ACTIVE is entered only on a later sof.
REQ-016 Format conversion (per-source data d):
- fmt 0: R,G,B = d[23:16], d[15:8], d[7:0].
- fmt 1: R = G = B = d[7:0].
- fmt 2: R = {d[15:11],d[15:13]}, G = {d[10:5],d[10:9]}, B = {d[4:0],d[4:2]} (bit replication).
- fmt 3: treated as fmt 0.
REQ-017 out_data is 0 whenever out_de=0.
REQ-018 Pixel counter: 24 bits, saturating; counts out_de cycles; cleared on every SOF taken in ACTIVE.
REQ-019 Count check: on sof[cur_sel] in ACTIVE, if a complete frame has elapsed since ACTIVE entry and count != SRC_H*SRC_V:
- err_pulse=1 for 1 cycle;
- err_cnt increments, saturating at 255.
REQ-020 No count check occurs on the SOF that enters ACTIVE, nor on the SOF that triggers a source switch.

Reset
REQ-021 When rstn=0, the following are cleared asynchronously: state=WAIT_SOF, cur_sel=0, cur_fmt=0, out_vs=0, out_de=0, out_data=0, switch_pending=0, frame_cnt=0, err_pulse=0, err_cnt=0, pixel counter=0, all src_vs_d=0.
REQ-022 Reset mid-frame drops the frame in progress; after release, output resumes only at the next sof[0].

Verification
REQ-023 Reset, source 0 RGB888, 4x2 test frames (SRC_H=4, SRC_V=2) -> out_vs first high on the cycle after the SOF; 8 out_de pulses per frame; out_data = {d,8'hFF}; frame_cnt = 1, 2, 3.
REQ-024 Source 1, fmt_req=2, d=16'hF81F -> out_data = 32'hFF00FFFF.
REQ-025 Source 0, fmt_req=1, d=8'h5A -> out_data = 32'h5A5A5AFF.
REQ-026 sel_req changes 0->2 mid-frame ->
- switch_pending=1 until sof[0];
- output blank until the next sof[2], then source 2 data;
- frame_cnt unchanged across the switch;
- err_cnt=0.
REQ-027 Source 0 delivers 7 pixels in one frame (SRC_H=4, SRC_V=2) -> err_pulse=1 for 1 cycle at the next sof[0]; err_cnt=1. After 300 bad frames -> err_cnt=255.
REQ-028 Further directed cases:
- sel_req=NUM_SRC -> switch_pending stays 0 and cur_sel is unchanged.
- rstn low mid-frame -> all outputs are 0 immediately.
